// File: rtl/fft_unloader_pkg.sv
// ============================================================================
// fft_unloader_pkg : FFT sizing defaults, bit-reversal and bank/address map
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fft_unloader_pkg;

  localparam int R_DEF  = 5;
  localparam int N_DEF  = 32;
  localparam int W_DEF  = 32;
  // Widest index the helpers support; callers cast down to their own R.
  localparam int IDX_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } unload_state_e;

  function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] k, input int r);
    logic [IDX_W-1:0] res;
    res = '0;
    for (int i = 0; i < IDX_W; i++) begin
      if (i < r) res[i] = k[r-1-i];
    end
    return res;
  endfunction

  // Conflict-free split: even-parity elements in m0, odd-parity in m1.
  function automatic logic bank_of(input logic [IDX_W-1:0] n);
    return ^n;
  endfunction

  function automatic logic [IDX_W-2:0] bank_addr(input logic [IDX_W-1:0] n);
    return n[IDX_W-1:1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_unload_fifo.sv
// ============================================================================
// fft_unload_fifo : 3-entry FIFO holding returned samples; head drives output
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fft_unload_fifo #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic [W-1:0] mem_q [3];
  logic [1:0]   wr_q;
  logic [1:0]   rd_q;
  logic [1:0]   cnt_q;
  logic         w_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_pop   = i_pop & (cnt_q != 2'd0);
  assign o_data  = mem_q[rd_q];
  assign o_valid = (cnt_q != 2'd0);
  assign o_count = cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      cnt_q <= 2'd0;
    end else begin
      if (i_push) begin
        mem_q[wr_q] <= i_data;
        wr_q        <= ptr_inc(wr_q);
      end
      if (w_pop) rd_q <= ptr_inc(rd_q);
      case ({i_push, w_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fft_unloader.sv
// ============================================================================
// fft_unloader : streams a finished FFT frame out of two banks in natural order
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fft_unloader
  import fft_unloader_pkg::*;
#(
  parameter int R = R_DEF,
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  output logic         o_m0_ren,
  output logic [R-2:0] o_m0_raddr,
  input  logic [W-1:0] i_m0_rdata,
  output logic         o_m1_ren,
  output logic [R-2:0] o_m1_raddr,
  input  logic [W-1:0] i_m1_rdata,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_busy,
  output logic         o_done
);

  localparam int AW = R - 1;

  unload_state_e state_q, state_d;
  logic [R-1:0]  k_q, k_d;
  logic [R-1:0]  out_cnt_q, out_cnt_d;
  logic          m0_ren_q, m0_ren_d, m1_ren_q, m1_ren_d;
  logic [AW-1:0] m0_raddr_q, m0_raddr_d, m1_raddr_q, m1_raddr_d;
  logic          rvalid_q, rbank_q;
  logic          done_q, done_d;

  logic [R-1:0]  w_n;
  logic          w_bank;
  logic [AW-1:0] w_addr;
  logic          w_pop, w_issue, w_can_issue;
  logic [1:0]    w_fifo_cnt;
  logic [2:0]    w_load;

  assign w_n    = R'(bitrev(IDX_W'(k_q), R));
  assign w_bank = bank_of(IDX_W'(w_n));
  assign w_addr = AW'(bank_addr(IDX_W'(w_n)));

  assign w_pop  = o_valid & i_ready;
  // Samples buffered plus reads still returning must leave room for this one.
  assign w_load      = {1'b0, w_fifo_cnt} + {2'b0, m0_ren_q | m1_ren_q} + {2'b0, rvalid_q};
  assign w_can_issue = w_load < (3'd3 + {2'b0, w_pop});

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    w_issue   = 1'b0;
    if (w_pop) out_cnt_d = out_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          w_issue = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_can_issue) begin
          w_issue = 1'b1;
          if (k_q == R'(N-1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_pop && (out_cnt_q == R'(N-1))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (w_issue) k_d = k_q + 1'b1;
  end

  assign m0_ren_d   = w_issue & ~w_bank;
  assign m1_ren_d   = w_issue &  w_bank;
  assign m0_raddr_d = m0_ren_d ? w_addr : m0_raddr_q;
  assign m1_raddr_d = m1_ren_d ? w_addr : m1_raddr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      out_cnt_q  <= '0;
      m0_ren_q   <= 1'b0;
      m1_ren_q   <= 1'b0;
      m0_raddr_q <= '0;
      m1_raddr_q <= '0;
      rvalid_q   <= 1'b0;
      rbank_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      out_cnt_q  <= out_cnt_d;
      m0_ren_q   <= m0_ren_d;
      m1_ren_q   <= m1_ren_d;
      m0_raddr_q <= m0_raddr_d;
      m1_raddr_q <= m1_raddr_d;
      rvalid_q   <= m0_ren_q | m1_ren_q;
      rbank_q    <= m1_ren_q;
      done_q     <= done_d;
    end
  end

  fft_unload_fifo #(.W(W)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (rvalid_q),
    .i_data  (rbank_q ? i_m1_rdata : i_m0_rdata),
    .i_pop   (w_pop),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_count (w_fifo_cnt)
  );

  assign o_m0_ren   = m0_ren_q;
  assign o_m1_ren   = m1_ren_q;
  assign o_m0_raddr = m0_raddr_q;
  assign o_m1_raddr = m1_raddr_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_unloader.sv
// ============================================================================
// tb_fft_unloader : randomized bench for fft_unloader with a frame-level model
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fft_unloader;

  localparam int R = 5;
  localparam int N = 32;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, ready;
  logic         m0_ren, m1_ren;
  logic [R-2:0] m0_raddr, m1_raddr;
  logic [W-1:0] m0_rdata, m1_rdata;
  logic [W-1:0] o_data;
  logic         o_valid, o_busy, o_done;

  always #5 clk = ~clk;

  fft_unloader #(.R(R), .N(N), .W(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_m0_ren(m0_ren), .o_m0_raddr(m0_raddr), .i_m0_rdata(m0_rdata),
    .o_m1_ren(m1_ren), .o_m1_raddr(m1_raddr), .i_m1_rdata(m1_rdata),
    .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Frame contents by element index n, and the two banks as memory would hold them
  logic [W-1:0] elem   [N];
  logic [W-1:0] m0_mem [N/2];
  logic [W-1:0] m1_mem [N/2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit rdy_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read banks; garbage on the bus whenever no read was issued
  always @(posedge clk) begin
    m0_rdata <= m0_ren ? m0_mem[m0_raddr] : $urandom;
    m1_rdata <= m1_ren ? m1_mem[m1_raddr] : $urandom;
  end

  function automatic int rev(input int k);
    int r = 0;
    for (int i = 0; i < R; i++) if (((k >> i) & 1) != 0) r = r | (1 << (R-1-i));
    return r;
  endfunction

  function automatic int bank_of(input int n);
    return $countones(n) % 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_frame(input bit use_index);
    for (int n = 0; n < N; n++) begin
      elem[n] = use_index ? W'(n) : $urandom;
      if (bank_of(n) == 0) m0_mem[n/2] = elem[n];
      else                 m1_mem[n/2] = elem[n];
    end
  endtask

  // ---------------- frame-level model and compare process ----------------
  bit           armed = 1'b0, exp_rst = 1'b0, m_busy = 1'b0, busy_now;
  bit           first_valid = 1'b0, stall_prev = 1'b0;
  int           m_rd = N, m_out = N, frames = 0;
  int           start_cyc = 0, done_exp = -1, done_cyc = 0, first_hs = 0, last_hs = 0;
  int           exp_n;
  logic [W-1:0] prev_data;
  logic [R-2:0] prev_a0, prev_a1;
  logic         obs_bank [N];
  logic [R-2:0] obs_addr [N];
  logic [W-1:0] obs_data [N];

  always @(negedge clk) begin
    if (!armed) begin
      if (rst) begin armed = 1'b1; exp_rst = 1'b1; end
    end else if (rst) begin
      exp_rst = 1'b1; m_busy = 1'b0; m_rd = N; m_out = N;
      done_exp = -1; stall_prev = 1'b0;
    end else if (exp_rst) begin
      chk("rst_m0_ren", m0_ren, 0);   chk("rst_m1_ren", m1_ren, 0);
      chk("rst_m0_raddr", m0_raddr, 0); chk("rst_m1_raddr", m1_raddr, 0);
      chk("rst_valid", o_valid, 0);   chk("rst_data", o_data, 0);
      chk("rst_busy", o_busy, 0);     chk("rst_done", o_done, 0);
      exp_rst = 1'b0;
      stall_prev = 1'b0;
    end else begin
      busy_now = m_busy;
      chk("busy", o_busy, busy_now);
      chk("done", o_done, cyc == done_exp);
      if (o_done) done_cyc = cyc;

      if (m0_ren || m1_ren) begin
        chk("ren_one_bank", m0_ren & m1_ren, 0);
        chk("read_allowed", busy_now && m_rd < N, 1);
        if (busy_now && m_rd < N) begin
          exp_n = rev(m_rd);
          chk("rd_bank", m1_ren, bank_of(exp_n));
          chk("rd_addr", m1_ren ? m1_raddr : m0_raddr, exp_n / 2);
          if (m_rd == 0) chk("rd_latency", cyc - start_cyc, 1);
          chk("outstanding_le3", (m_rd + 1 - m_out) <= 3, 1);
          obs_bank[m_rd] = m1_ren;
          obs_addr[m_rd] = m1_ren ? m1_raddr : m0_raddr;
          m_rd++;
        end
      end
      if (!m0_ren) chk("m0_raddr_hold", m0_raddr, prev_a0);
      if (!m1_ren) chk("m1_raddr_hold", m1_raddr, prev_a1);

      if (stall_prev) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_data", o_data, prev_data);
      end
      if (o_valid && busy_now && !first_valid) begin
        chk("valid_latency", cyc - start_cyc, 3);
        first_valid = 1'b1;
      end

      if (o_valid && ready) begin
        chk("xfer_allowed", busy_now && m_out < N, 1);
        if (busy_now && m_out < N) begin
          chk("data", o_data, elem[rev(m_out)]);
          obs_data[m_out] = o_data;
          if (m_out == 0) first_hs = cyc;
          last_hs = cyc;
          m_out++;
          if (m_out == N) begin
            m_busy = 1'b0; done_exp = cyc + 1; frames++;
          end
        end
      end

      if (start && !busy_now) begin
        m_busy = 1'b1; start_cyc = cyc; m_rd = 0; m_out = 0; first_valid = 1'b0;
      end
      stall_prev = o_valid && !ready;
    end
    prev_data = o_data;
    prev_a0   = m0_raddr;
    prev_a1   = m1_raddr;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) ready = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
  endtask

  task automatic wait_frames(input int target, input int max_cyc);
    int t = 0;
    while (frames < target && t < max_cyc) begin tick(); t++; end
    chk("frame_timeout", frames >= target, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    m0_rdata = '0; m1_rdata = '0;
    load_frame(1'b1);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Frame 1: contents = n, ready held high, exact latency and address map
    start = 1'b1; tick(); start = 1'b0;
    wait_frames(1, 200);
    tick();
    chk("f1_first_out", first_hs - start_cyc, 3);
    chk("f1_contiguous", last_hs - first_hs, N - 1);
    chk("f1_done_cycle", done_cyc - start_cyc, 35);
    chk("map_k0_bank", obs_bank[0], 0);   chk("map_k0_addr", obs_addr[0], 0);
    chk("map_k1_bank", obs_bank[1], 1);   chk("map_k1_addr", obs_addr[1], 8);
    chk("map_k3_bank", obs_bank[3], 0);   chk("map_k3_addr", obs_addr[3], 12);
    chk("map_k31_bank", obs_bank[31], 1); chk("map_k31_addr", obs_addr[31], 15);
    chk("pin_out1", obs_data[1], 16);
    chk("pin_out2", obs_data[2], 8);
    chk("pin_out3", obs_data[3], 24);
    chk("pin_out31", obs_data[31], 31);

    // Frame 2: contents = n, random ready, spurious starts while busy
    rdy_rand = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    t = 0;
    while (frames < 2 && t < 400) begin
      start = (m_busy && m_rd < N/2 && $urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      tick(); t++;
    end
    start = 1'b0;
    chk("f2_timeout", frames >= 2, 1);

    // Frame 3: downstream stalled for 20 cycles after start
    load_frame(1'b0);
    rdy_rand = 1'b0; ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (19) tick();
    chk("stall_read_count", m_rd, 3);
    ready = 1'b1;
    wait_frames(3, 200);

    // Frames 4/5: start presented in the done cycle of the previous frame
    load_frame(1'b0);
    rdy_rand = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    t = 0;
    while (!o_done && t < 400) begin tick(); t++; end
    chk("b2b_done_seen", o_done, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("b2b_ren", m0_ren | m1_ren, 1);
    wait_frames(5, 400);

    // Frame 6: ignored start then reset at k=10, then a clean frame
    load_frame(1'b0);
    start = 1'b1; tick(); start = 1'b0;
    t = 0;
    while (m_rd < 10 && t < 200) begin tick(); t++; end
    chk("k10_reached", m_rd >= 10, 1);
    start = 1'b1; tick(); start = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    chk("abort_no_frame", frames, 5);
    load_frame(1'b0);
    rdy_rand = 1'b0; ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_frames(6, 200);
    chk("restart_k0_bank", obs_bank[0], 0);
    chk("restart_k0_addr", obs_addr[0], 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
